// File: rtl/avalon_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_pkt_arbiter
// Description : Packet-level round-robin arbiter sharing one Avalon-ST
//               datapath between NUM_INPUTS sources. A grant is held from a
//               packet's first beat through its eop beat, so packets are never
//               interleaved. One bubble cycle is spent in IDLE per packet.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in_valid/in_ready - per-input handshake
//               in_data/in_sop/in_eop/in_empty - per-input payload (packed)
//               out_valid/out_ready/out_data/out_sop/out_eop/out_empty
//                                 - shared output stream
//               grant_idx, busy   - current grant (valid while busy=1)
//               orphan_cnt        - drained orphan beats (optional feature)
// Options     : AVST_ARB_DROP_ORPHAN_EN - when defined, IDLE drains beats
//               without sop, counts them on orphan_cnt and only grants
//               inputs presenting sop.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_pkt_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS-1:0]             in_valid,
    output logic [NUM_INPUTS-1:0]             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]             in_sop,
    input  logic [NUM_INPUTS-1:0]             in_eop,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic [EMPTY_WIDTH-1:0]            out_empty,
    output logic [$clog2(NUM_INPUTS)-1:0]     grant_idx,
    output logic                              busy
`ifdef AVST_ARB_DROP_ORPHAN_EN
    ,
    output logic [15:0]                       orphan_cnt
`endif
);

    localparam int c_GW = $clog2(NUM_INPUTS);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_GW-1:0]        r_grant;
    logic [c_GW-1:0]        r_rr_ptr;
    logic [c_GW-1:0]        w_winner;
    logic                   w_found;
    logic [NUM_INPUTS-1:0]  w_eligible;
    logic                   w_sel_valid;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_sop;
    logic                   w_sel_eop;
    logic [EMPTY_WIDTH-1:0] w_sel_empty;
    logic                   w_eop_xfer;

`ifdef AVST_ARB_DROP_ORPHAN_EN
    // Only packet starts compete; a beat without sop in IDLE is an orphan.
    assign w_eligible = in_valid & in_sop;
`else
    assign w_eligible = in_valid;
`endif

    // Round-robin scan: first eligible input at or above r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!w_found && w_eligible[(int'(r_rr_ptr) + k) % NUM_INPUTS]) begin
                w_found  = 1'b1;
                w_winner = c_GW'((int'(r_rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    // Payload mux from the granted input.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_empty = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (c_GW'(i) == r_grant) begin
                w_sel_valid = in_valid[i];
                w_sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_sop   = in_sop[i];
                w_sel_eop   = in_eop[i];
                w_sel_empty = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            end
        end
    end

    assign busy       = (r_state == c_ST_GRANT);
    assign grant_idx  = r_grant;
    assign out_valid  = busy & w_sel_valid;
    assign out_data   = w_sel_data;
    assign out_sop    = w_sel_sop;
    assign out_eop    = w_sel_eop;
    assign out_empty  = w_sel_empty;
    assign w_eop_xfer = busy & w_sel_valid & out_ready & w_sel_eop;

    // Ready in GRANT follows out_ready only, never the input's own valid.
    always_comb begin
        in_ready = '0;
        if (r_state == c_ST_GRANT) begin
            in_ready[r_grant] = out_ready;
        end
`ifdef AVST_ARB_DROP_ORPHAN_EN
        else begin
            in_ready = in_valid & ~in_sop;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_found)    w_state_nxt = c_ST_GRANT;
            c_ST_GRANT: if (w_eop_xfer) w_state_nxt = c_ST_IDLE;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE && w_found) begin
                r_grant <= w_winner;
            end
            // Priority moves just past the input whose packet completed.
            if (w_eop_xfer) begin
                r_rr_ptr <= (r_grant == c_GW'(NUM_INPUTS - 1)) ? '0
                                                               : r_grant + c_GW'(1);
            end
        end
    end

`ifdef AVST_ARB_DROP_ORPHAN_EN
    logic [NUM_INPUTS-1:0] w_drain;
    logic [16:0]           w_cnt_sum;
    logic [15:0]           r_orphan_cnt;

    // Several inputs may drain in the same cycle; add all of them, then saturate.
    always_comb begin
        w_drain   = (r_state == c_ST_IDLE) ? (in_valid & ~in_sop) : '0;
        w_cnt_sum = {1'b0, r_orphan_cnt};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_cnt_sum = w_cnt_sum + 17'(w_drain[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_orphan_cnt <= '0;
        end else begin
            r_orphan_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign orphan_cnt = r_orphan_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_st_pkt_arbiter
// Description : Directed self-checking bench for avalon_st_pkt_arbiter.
//               Per-input packet sources advance on observed handshakes;
//               expected output values are hand-computed per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_st_pkt_arbiter;

    localparam int c_N  = 4;
    localparam int c_DW = 128;
    localparam int c_EW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_N-1:0]        in_valid;
    logic [c_N-1:0]        in_ready;
    logic [c_N*c_DW-1:0]   in_data;
    logic [c_N-1:0]        in_sop;
    logic [c_N-1:0]        in_eop;
    logic [c_N*c_EW-1:0]   in_empty;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_DW-1:0]       out_data;
    logic                  out_sop;
    logic                  out_eop;
    logic [c_EW-1:0]       out_empty;
    logic [1:0]            grant_idx;
    logic                  busy;
`ifdef AVST_ARB_DROP_ORPHAN_EN
    logic [15:0]           orphan_cnt;
`endif

    avalon_st_pkt_arbiter #(
        .NUM_INPUTS (c_N),
        .DATA_WIDTH (c_DW),
        .EMPTY_WIDTH(c_EW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_empty  (in_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef AVST_ARB_DROP_ORPHAN_EN
        ,
        .orphan_cnt(orphan_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source model state
    bit       src_on    [c_N];
    bit       src_rep   [c_N];
    bit       src_nosop [c_N];
    int       src_len   [c_N];
    int       src_beat  [c_N];
    logic [3:0] src_tag   [c_N];
    logic [3:0] src_empty [c_N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] sdata(input int i, input int b);
        return 128'(src_tag[i]) * 128'd16 + 128'(b + 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < c_N; i++) begin
            in_valid[i] = src_on[i];
            in_sop[i]   = src_on[i] && (src_beat[i] == 0) && !src_nosop[i];
            in_eop[i]   = (src_beat[i] == src_len[i] - 1);
            in_data[i*c_DW +: c_DW]  = sdata(i, src_beat[i]);
            in_empty[i*c_EW +: c_EW] = in_eop[i] ? src_empty[i] : 4'd0;
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < c_N; i++) begin
            src_on[i] = 0; src_rep[i] = 0; src_nosop[i] = 0;
            src_len[i] = 1; src_beat[i] = 0; src_tag[i] = 0; src_empty[i] = 0;
        end
    endtask

    task automatic src_set(input int i, input int len, input logic [3:0] tag,
                           input logic [3:0] emp, input bit rep);
        src_on[i] = 1; src_len[i] = len; src_tag[i] = tag;
        src_empty[i] = emp; src_rep[i] = rep; src_beat[i] = 0;
    endtask

    // Called at a negedge: capture handshakes, cross the edge, advance sources.
    task automatic adv();
        logic [c_N-1:0] hs;
        hs = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < c_N; i++) begin
            if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    if (!src_rep[i]) src_on[i] = 0;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_clear();
        drive();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_ovld"},  out_valid, 0);
        chk({tag, "_irdy"},  in_ready, 0);
    endtask

    task automatic chk_beat(input string tag, input int g, input logic [127:0] d,
                            input bit sop, input bit eop, input logic [3:0] ir);
        chk({tag, "_busy"},  busy, 1);
        chk({tag, "_gnt"},   grant_idx, g);
        chk({tag, "_ovld"},  out_valid, 1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_sop"},   out_sop, sop);
        chk({tag, "_eop"},   out_eop, eop);
        chk({tag, "_irdy"},  in_ready, ir);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        int last;
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};

        // ---- reset state ----
        rst = 1'b1;
        out_ready = 1'b1;
        src_clear();
        drive();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ovld", out_valid, 0);
        chk("rst_irdy", in_ready, 0);
        chk("rst_gnt",  grant_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- A: 3-beat packet on input 2 ----
        src_set(2, 3, 4'hA, 4'h0, 0);
        drive();
        @(negedge clk); chk_idle("a_bub"); adv();
        @(negedge clk); chk_beat("a1", 2, 'hA1, 1, 0, 4'b0100); adv();
        @(negedge clk); chk_beat("a2", 2, 'hA2, 0, 0, 4'b0100); adv();
        @(negedge clk); chk_beat("a3", 2, 'hA3, 0, 1, 4'b0100);
        chk("a3_empty", out_empty, 0);
        adv();
        @(negedge clk); chk_idle("a_done");

        // ---- B: inputs 0 and 3 single-beat; rr_ptr=3 must pick 3 first ----
        adv();
        src_set(0, 1, 4'hB, 4'h0, 0);
        src_set(3, 1, 4'hC, 4'h5, 0);
        drive();
        @(negedge clk); chk_idle("b_bub0"); adv();
        @(negedge clk); chk_beat("b_g3", 3, 'hC1, 1, 1, 4'b1000);
        chk("b_empty", out_empty, 5);
        adv();
        @(negedge clk); chk_idle("b_bub1"); adv();
        @(negedge clk); chk_beat("b_g0", 0, 'hB1, 1, 1, 4'b0001); adv();
        @(negedge clk); chk_idle("b_done");

        // ---- C: input 1, 4-beat packet, out_ready toggling ----
        adv();
        src_set(1, 4, 4'h5, 4'h3, 0);
        drive();
        @(negedge clk); chk_idle("c_bub"); adv();
        b = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready = (k % 2 == 0);
            @(negedge clk);
            chk("c_ovld", out_valid, 1);
            chk("c_gnt",  grant_idx, 1);
            chk("c_data", out_data, 128'h50 + 128'(b + 1));
            chk("c_eop",  out_eop, (b == 3));
            chk("c_irdy", in_ready, out_ready ? 4'b0010 : 4'b0000);
            if (out_ready) b++;
            adv();
        end
        out_ready = 1'b1;
        @(negedge clk); chk_idle("c_done");

        // ---- D: reset on 2nd beat of a packet from input 1 ----
        adv();
        src_set(1, 4, 4'h6, 4'h0, 0);
        drive();
        @(negedge clk); chk_idle("d_bub"); adv();
        @(negedge clk); chk_beat("d_b0", 1, 'h61, 1, 0, 4'b0010); adv();
        rst = 1'b1;
        @(negedge clk);
        chk_idle("d_rst");
        chk("d_rst_gnt", grant_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_clear();
        src_set(1, 1, 4'h7, 4'h0, 0);
        src_set(3, 1, 4'h8, 4'h0, 0);
        drive();
        @(negedge clk); chk_idle("d_bub1"); adv();
        @(negedge clk); chk_beat("d_g1", 1, 'h71, 1, 1, 4'b0010); adv();
        @(negedge clk); chk_idle("d_bub2"); adv();
        @(negedge clk); chk_beat("d_g3", 3, 'h81, 1, 1, 4'b1000); adv();
        @(negedge clk); chk_idle("d_done");

        // ---- E: fairness, all inputs with continuous 2-beat packets ----
        do_reset();
        for (int i = 0; i < c_N; i++) src_set(i, 2, 4'(i + 1), 4'h0, 1);
        drive();
        n = 0;
        last = -1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("e_data", out_data, sdata(int'(grant_idx), src_beat[grant_idx]));
                chk("e_sop",  out_sop, (src_beat[grant_idx] == 0));
                if (out_sop) begin
                    order[n] = int'(grant_idx);
                    n++;
                    last = int'(grant_idx);
                end else begin
                    chk("e_contig", grant_idx, last);
                end
            end
            adv();
        end
        chk("e_count", n, 5);
        for (int i = 0; i < 5; i++) chk("e_order", order[i], exp_order[i]);

        // ---- F: single-beat on 0 and 3 from rr_ptr=0 ----
        do_reset();
        src_set(0, 1, 4'hB, 4'h0, 0);
        src_set(3, 1, 4'hC, 4'h0, 0);
        drive();
        @(negedge clk); chk_idle("f_bub0"); adv();
        @(negedge clk); chk_beat("f_g0", 0, 'hB1, 1, 1, 4'b0001); adv();
        @(negedge clk); chk_idle("f_bub1"); adv();
        @(negedge clk); chk_beat("f_g3", 3, 'hC1, 1, 1, 4'b1000); adv();
        @(negedge clk); chk_idle("f_done");

`ifdef AVST_ARB_DROP_ORPHAN_EN
        // ---- G: orphan beats drained and counted ----
        do_reset();
        src_set(0, 2, 4'h9, 4'h0, 0);
        src_nosop[0] = 1;
        drive();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("g_irdy", in_ready, 4'b0001);
            chk("g_ovld", out_valid, 0);
            chk("g_busy", busy, 0);
            adv();
        end
        @(negedge clk);
        chk("g_cnt", orphan_cnt, 2);
        chk("g_irdy_off", in_ready, 0);
        adv();
        src_nosop[0] = 0;
        src_set(0, 1, 4'hD, 4'h0, 0);
        drive();
        @(negedge clk); chk_idle("g_bub"); adv();
        @(negedge clk); chk_beat("g_g0", 0, 'hD1, 1, 1, 4'b0001); adv();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_st_pkt_arbiter.md
Name: avalon_st_pkt_arbiter

Overview:
Packet-level round-robin arbiter that shares one Avalon-ST datapath (e.g. the header stripping stage) between NUM_INPUTS Avalon-ST sources. A grant is held from the granted input's first beat through its eop beat, so packets are never interleaved. Sits directly upstream of the shared stream consumer. Exports the current grant so downstream logic can tag the source of each packet.

Parameters:
- NUM_INPUTS, 4, number of requesting streams (2..16)
- DATA_WIDTH, 128, data bits per beat
- EMPTY_WIDTH, 4, width of the empty field (log2 of DATA_WIDTH/8)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  NUM_INPUTS  per-input valid
- in_ready  out  NUM_INPUTS  per-input ready
- in_data  in  NUM_INPUTS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_sop  in  NUM_INPUTS  per-input start of packet
- in_eop  in  NUM_INPUTS  per-input end of packet
- in_empty  in  NUM_INPUTS*EMPTY_WIDTH  per-input empty, packed like in_data
- out_valid  out  1  shared stream valid
- out_ready  in  1  shared stream ready
- out_data  out  DATA_WIDTH  muxed data
- out_sop  out  1  muxed sop
- out_eop  out  1  muxed eop
- out_empty  out  EMPTY_WIDTH  muxed empty
- grant_idx  out  $clog2(NUM_INPUTS)  index of the granted input; valid while busy=1
- busy  out  1  high in GRANT state

Behaviour:
- A beat transfers on a port when valid & ready are both high in the same cycle.
- State machine:
  - IDLE: no grant.
  - GRANT: locked to grant_idx.
- IDLE:
  - All in_ready=0, out_valid=0.
  - If any in_valid=1, pick the winner: the first input with in_valid=1 scanning upward from rr_ptr, wrapping NUM_INPUTS-1 to 0.
  - Register the winner into grant_idx and go to GRANT next cycle. This gives exactly 1 bubble cycle per packet.
- GRANT (combinational mux from input g=grant_idx):
  - out_valid=in_valid[g]; out_data, out_sop, out_eop and out_empty come from input g.
  - in_ready[g]=out_ready; all other in_ready=0.
  - in_ready never depends on in_valid.
- On a transferred beat with in_eop[g]=1: return to IDLE and set rr_ptr=(g+1) mod NUM_INPUTS.
- A single-beat packet (sop and eop on the same beat) returns to IDLE after that one beat.
- A non-eop beat keeps the grant. The grant is held indefinitely while in_valid[g]=0 (no timeout).
- A sop seen mid-packet on the granted input is passed through unchanged; no checking.
- Requests from non-granted inputs are ignored until IDLE. Their valid/data must stay stable under standard Avalon-ST rules, so nothing is lost.
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, in_ready=0, out_valid=0.
- Reset mid-packet: the grant is abandoned immediately; the downstream sees a truncated packet and must handle it.
- Fairness: with all inputs continuously requesting, grants rotate 0,1,2,3,0,...
- Throughput: one beat per cycle inside a packet; 1 idle cycle between packets.

Optional Feature:
- Macro: AVST_ARB_DROP_ORPHAN_EN.
- Defined:
  - In IDLE, an input presenting in_valid=1 with in_sop=0 is an orphan and does not take part in arbitration.
  - Orphans are drained: in_ready[i]=1 for that beat, data discarded.
  - Each drained beat increments a 16-bit saturating counter, exposed on an extra output port orphan_cnt (16 bits, reset 0).
  - Only inputs with in_valid & in_sop are granted.
- Not defined: any in_valid is granted regardless of sop; no orphan_cnt port exists.

Test Plan:
- Reset, then input 2 sends a 3-beat packet (data 0xA1..0xA3, empty=0 on the last beat):
  - out shows idle bubble, then A1(sop), A2, A3(eop).
  - grant_idx=2, busy=1 for 3 cycles, then busy=0; rr_ptr becomes 3.
- All 4 inputs continuously offer 2-beat packets, out_ready=1:
  - grant order 0,1,2,3,0.
  - Each packet's beats are contiguous and never interleaved.
- Input 1 granted, out_ready toggles 1,0,1,0 during a 4-beat packet:
  - out stalls on ready=0 beats; in_ready[1] tracks out_ready.
  - Other in_ready stay 0; all 4 beats arrive in order.
- Single-beat packets (sop=eop=1) on inputs 0 and 3 simultaneously from rr_ptr=0:
  - input 0 granted, then input 3, each for 1 beat with 1 bubble.
- Assert rst on the 2nd beat of a 4-beat packet from input 1:
  - same cycle: out_valid=0, in_ready=0, busy=0.
  - after release, a new request on input 1 is granted from rr_ptr=0 arbitration.
- With AVST_ARB_DROP_ORPHAN_EN defined, input 0 presents 2 beats with sop=0 while in IDLE:
  - both beats accepted and dropped; orphan_cnt=2; no output beats.
  - a following sop packet on input 0 is then granted normally.
